gnr_node_lut: RTL and testbench
===============================

Name: gnr_node_lut

Overview:
Parametrised gene-regulatory-network Boolean node. It evaluates one N_IN-input Boolean function, given as a truth table, independently for N_CH state copies (channels).
- Each channel has a runtime update divider, which lets different copies update at different rates under a shared schedule.
- Each channel has a stability (fixed-point) detector.
- Sits in the GRN accelerator array next to the fixed-function nodes; the controller reads per-channel convergence from it.

Parameters:
N_IN, 4, number of regulator inputs per channel (1..6)
N_CH, 2, number of independent state copies
LUT, 16'hFFF8, truth table of 2**N_IN bits; bit idx is the next state for input vector idx. Default = (in0 & in1) | in2 | in3
DIV_W, 4, width of each per-channel divider value
STABLE_CNT, 8, consecutive unchanged updates needed to assert stable (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  global enable; channel updates occur only while high
reset_nos  in  1  synchronous network re-initialisation
init_state  in  N_CH  per-channel value loaded on reset_nos
start_ch  in  N_CH  per-channel update request
div  in  N_CH*DIV_W  per-channel divider; channel c uses bits [c*DIV_W +: DIV_W]
in_bits  in  N_CH*N_IN  channel c inputs at [c*N_IN +: N_IN]; bit i is LUT index bit i
state  out  N_CH  registered node state per channel
upd_valid  out  N_CH  one-cycle pulse; channel committed an update this edge
changed  out  N_CH  one-cycle pulse; the committed update changed state
stable  out  N_CH  channel has seen STABLE_CNT consecutive unchanged updates

Behaviour:
- Async reset: rst high immediately clears every register, independent of clk. state=0, upd_valid=0, changed=0, stable=0, divider counters=0, stability counters=0. Reset mid-update discards the update.
- Per channel c, priority order at each posedge:
  1. reset_nos: state<=init_state[c]; div_cnt<=0; stab_cnt<=0; upd_valid, changed, stable <= 0.
  2. Otherwise, if start & start_ch[c]:
     - If div_cnt==0: commit. nxt=LUT[in_bits slice]; state<=nxt; div_cnt<=div[c]; upd_valid<=1; changed<=(nxt!=state).
     - Else: div_cnt<=div_cnt-1; no commit; pulses <=0.
  3. Otherwise: hold state and counters; pulses <=0.
- Update rate: a channel commits once every div+1 qualifying start_ch cycles. div=0 commits every request. div=1 commits on the 1st, 3rd, 5th... request after reset_nos. div is sampled at commit time only.
- Latency: inputs are sampled at the commit edge. state and pulses are visible one cycle after the edge.
- Stability, evaluated on commit only:
  - nxt==state: stab_cnt saturating increment to STABLE_CNT.
  - nxt!=state: stab_cnt<=0.
  - stable is registered and equals (stab_cnt==STABLE_CNT) after the edge. It drops on the same edge as a changing commit or reset_nos.
- stab_cnt width is clog2(STABLE_CNT+1). div_cnt width is DIV_W.
- Channels are fully independent and may commit in the same cycle.
- start low freezes all dividers, states and stability counters.

Decomposition:
- Shared header gnr_defs: LUT default constant, clog2 function, channel slice macros.
- One sub-module, gnr_node_ch, holds one channel's divider, state, stability counter and pulses. The top generates N_CH instances and slices the buses.
- LUT, N_IN, DIV_W and STABLE_CNT are passed down unchanged.

Test Plan:
1. Drive rst high between clock edges with state=2'b11 and stable=2'b01 -> all outputs read 0 before the next edge and stay 0 while rst is held.
2. reset_nos=1 with init_state=2'b10 and start_ch=2'b11 in the same cycle -> state=2'b10 next cycle, upd_valid=0, stable=0. reset_nos has priority.
3. Channel 0: div=1, in=4'b0011, start=1, start_ch[0] high for 4 cycles after reset_nos with init 0 -> upd_valid[0] pulses after request edges 1 and 3 only. state[0]=1 after edge 1; changed[0] pulses only after edge 1.
4. Channel 1: div=0, sweep in_bits 0..15, one per cycle -> state[1] follows 16'hFFF8 one cycle later (0 for indices 0-2, 1 for 3-15). upd_valid[1] is high every cycle.
5. STABLE_CNT=8, div=0, constant in=4'b0100 after state=1 -> stable rises exactly after the 8th unchanged commit. Switching in to 4'b0000 then drops stable and pulses changed on the next commit.
6. start=0 with start_ch=2'b11 held for 5 cycles -> no pulses, state and divider counts frozen. On start=1, the divider resumes from its frozen value.

Source files
------------

// File: rtl/gnr_node_lut_pkg.sv
// Shared definitions for the GRN Boolean LUT node: default truth table and a
// constant-width helper used to size the stability counters.
package gnr_node_lut_pkg;

    // (in0 & in1) | in2 | in3 over a 4-input index
    localparam logic [15:0] LUT_DEFAULT = 16'hFFF8;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gnr_node_lut_ch.sv
// One channel of the GRN LUT node: update divider, node state, stability
// counter and the per-commit pulses.
module gnr_node_ch
    import gnr_node_lut_pkg::*;
#(
    parameter int                      N_IN       = 4,
    parameter logic [(2**N_IN)-1:0]    LUT        = LUT_DEFAULT,
    parameter int                      DIV_W      = 4,
    parameter int                      STABLE_CNT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reset_nos,
    input  logic              init_state,
    input  logic              start_ch,
    input  logic [DIV_W-1:0]  div,
    input  logic [N_IN-1:0]   in_bits,
    output logic              state,
    output logic              upd_valid,
    output logic              changed,
    output logic              stable
);

    localparam int              SW       = clog2(STABLE_CNT + 1);
    localparam logic [SW-1:0]   STAB_MAX = SW'(STABLE_CNT);

    logic [DIV_W-1:0] div_cnt;
    logic [SW-1:0]    stab_cnt;
    logic [SW-1:0]    stab_inc;
    logic             nxt;
    logic             request;

    assign nxt      = LUT[in_bits];
    assign request  = start & start_ch;
    assign stab_inc = (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + 1'b1;

    // Inputs are sampled only on the commit edge; the divider is reloaded there too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= 1'b0;
            div_cnt   <= '0;
            stab_cnt  <= '0;
            upd_valid <= 1'b0;
            changed   <= 1'b0;
            stable    <= 1'b0;
        end else if (reset_nos) begin
            state     <= init_state;
            div_cnt   <= '0;
            stab_cnt  <= '0;
            upd_valid <= 1'b0;
            changed   <= 1'b0;
            stable    <= 1'b0;
        end else if (request) begin
            if (div_cnt == '0) begin
                state     <= nxt;
                div_cnt   <= div;
                upd_valid <= 1'b1;
                changed   <= (nxt != state);
                if (nxt == state) begin
                    stab_cnt <= stab_inc;
                    stable   <= (stab_inc == STAB_MAX);
                end else begin
                    stab_cnt <= '0;
                    stable   <= 1'b0;
                end
            end else begin
                div_cnt   <= div_cnt - 1'b1;
                upd_valid <= 1'b0;
                changed   <= 1'b0;
            end
        end else begin
            upd_valid <= 1'b0;
            changed   <= 1'b0;
        end
    end

endmodule

// File: rtl/gnr_node_lut.sv
// Gene-regulatory-network Boolean node: one truth table evaluated independently
// for N_CH state copies, each with its own divider and stability detector.
module gnr_node_lut
    import gnr_node_lut_pkg::*;
#(
    parameter int                      N_IN       = 4,
    parameter int                      N_CH       = 2,
    parameter logic [(2**N_IN)-1:0]    LUT        = LUT_DEFAULT,
    parameter int                      DIV_W      = 4,
    parameter int                      STABLE_CNT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    reset_nos,
    input  logic [N_CH-1:0]         init_state,
    input  logic [N_CH-1:0]         start_ch,
    input  logic [N_CH*DIV_W-1:0]   div,
    input  logic [N_CH*N_IN-1:0]    in_bits,
    output logic [N_CH-1:0]         state,
    output logic [N_CH-1:0]         upd_valid,
    output logic [N_CH-1:0]         changed,
    output logic [N_CH-1:0]         stable
);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        gnr_node_ch #(
            .N_IN       (N_IN),
            .LUT        (LUT),
            .DIV_W      (DIV_W),
            .STABLE_CNT (STABLE_CNT)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .reset_nos  (reset_nos),
            .init_state (init_state[c]),
            .start_ch   (start_ch[c]),
            .div        (div[c*DIV_W +: DIV_W]),
            .in_bits    (in_bits[c*N_IN +: N_IN]),
            .state      (state[c]),
            .upd_valid  (upd_valid[c]),
            .changed    (changed[c]),
            .stable     (stable[c])
        );
    end

endmodule

// File: tb/tb_gnr_node_lut.sv
// Directed self-checking bench for gnr_node_lut with the default parameters
// (4 inputs, 2 channels, truth table 16'hFFF8, 4-bit dividers, STABLE_CNT=8).
module tb_gnr_node_lut;

    logic       clk;
    logic       rst;
    logic       start;
    logic       reset_nos;
    logic [1:0] init_state;
    logic [1:0] start_ch;
    logic [7:0] div;
    logic [7:0] in_bits;
    logic [1:0] state;
    logic [1:0] upd_valid;
    logic [1:0] changed;
    logic [1:0] stable;

    int n_cmp;
    int n_fail;

    gnr_node_lut dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reset_nos  (reset_nos),
        .init_state (init_state),
        .start_ch   (start_ch),
        .div        (div),
        .in_bits    (in_bits),
        .state      (state),
        .upd_valid  (upd_valid),
        .changed    (changed),
        .stable     (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // div and in_bits are packed {ch1, ch0}
    task automatic applyStimulus(input logic nos, input logic [1:0] init, input logic st,
                                 input logic [1:0] sch, input logic [7:0] dv, input logic [7:0] ib);
        reset_nos  = nos;
        init_state = init;
        start      = st;
        start_ch   = sch;
        div        = dv;
        in_bits    = ib;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel 0 holds state 1 with input 0100; stable must rise only on the 8th commit.
    task automatic stabRamp(input string tag);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput({tag, "_stable"}, 32'(stable[0]), 32'(k == 8));
            checkOutput({tag, "_state"}, 32'(state[0]), 32'd1);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 8'h00, 8'h00);
        tick();
        tick();
        checkOutput("por_state", 32'(state), 32'd0);
        checkOutput("por_stable", 32'(stable), 32'd0);
        rst = 1'b0;

        // Build state=11, stable=01 then assert rst between edges
        applyStimulus(1'b1, 2'b11, 1'b0, 2'b00, 8'h00, 8'h00);
        tick();
        checkOutput("nos_init11", 32'(state), 32'd3);
        applyStimulus(1'b0, 2'b11, 1'b1, 2'b01, 8'h00, 8'h04);
        stabRamp("ramp1");
        checkOutput("pre_rst_state", 32'(state), 32'd3);
        checkOutput("pre_rst_stable", 32'(stable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_state", 32'(state), 32'd0);
        checkOutput("async_stable", 32'(stable), 32'd0);
        checkOutput("async_upd", 32'(upd_valid), 32'd0);
        checkOutput("async_changed", 32'(changed), 32'd0);
        tick();
        tick();
        checkOutput("rst_held", 32'({state, upd_valid, changed, stable}), 32'd0);
        rst = 1'b0;

        // reset_nos beats a simultaneous update request
        applyStimulus(1'b1, 2'b10, 1'b1, 2'b11, 8'h00, 8'hF3);
        tick();
        checkOutput("nos_prio_state", 32'(state), 32'd2);
        checkOutput("nos_prio_upd", 32'(upd_valid), 32'd0);
        checkOutput("nos_prio_stable", 32'(stable), 32'd0);
        checkOutput("nos_prio_changed", 32'(changed), 32'd0);

        // Channel 0 divider of 1: commits on requests 1 and 3
        applyStimulus(1'b1, 2'b00, 1'b1, 2'b00, 8'h01, 8'h03);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b1, 2'b01, 8'h01, 8'h03);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput($sformatf("div1_upd%0d", k), 32'(upd_valid), 32'(k % 2));
            checkOutput($sformatf("div1_chg%0d", k), 32'(changed), 32'(k == 1));
            checkOutput($sformatf("div1_st%0d", k), 32'(state), 32'd1);
        end

        // start low freezes everything; ch0 divider is left at 1
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b11, 8'h01, 8'hF0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput($sformatf("frz_upd%0d", k), 32'(upd_valid), 32'd0);
            checkOutput($sformatf("frz_chg%0d", k), 32'(changed), 32'd0);
            checkOutput($sformatf("frz_st%0d", k), 32'(state), 32'd1);
        end
        applyStimulus(1'b0, 2'b00, 1'b1, 2'b01, 8'h01, 8'h00);
        tick();
        checkOutput("resume_dec_upd", 32'(upd_valid), 32'd0);
        checkOutput("resume_dec_st", 32'(state), 32'd1);
        tick();
        checkOutput("resume_cmt_upd", 32'(upd_valid), 32'd1);
        checkOutput("resume_cmt_chg", 32'(changed), 32'd1);
        checkOutput("resume_cmt_st", 32'(state), 32'd0);

        // Channel 1 truth-table sweep with div 0
        applyStimulus(1'b1, 2'b00, 1'b1, 2'b00, 8'h00, 8'h00);
        tick();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            logic       exp;
            logic       prev;
            v    = 4'(i);
            exp  = (v[0] & v[1]) | v[2] | v[3];
            prev = state[1];
            applyStimulus(1'b0, 2'b00, 1'b1, 2'b10, 8'h00, {v, 4'h0});
            tick();
            checkOutput($sformatf("sweep_st%0d", i), 32'(state[1]), 32'(exp));
            checkOutput($sformatf("sweep_upd%0d", i), 32'(upd_valid), 32'd2);
            checkOutput($sformatf("sweep_chg%0d", i), 32'(changed[1]), 32'(exp != prev));
        end

        // Stability ramp, saturation, then a changing commit drops stable
        applyStimulus(1'b1, 2'b01, 1'b1, 2'b00, 8'h00, 8'h04);
        tick();
        applyStimulus(1'b0, 2'b01, 1'b1, 2'b01, 8'h00, 8'h04);
        stabRamp("ramp2");
        tick();
        tick();
        checkOutput("sat_stable", 32'(stable[0]), 32'd1);
        applyStimulus(1'b0, 2'b01, 1'b1, 2'b01, 8'h00, 8'h00);
        tick();
        checkOutput("drop_stable", 32'(stable[0]), 32'd0);
        checkOutput("drop_changed", 32'(changed[0]), 32'd1);
        checkOutput("drop_state", 32'(state[0]), 32'd0);
        tick();
        checkOutput("post_drop_stable", 32'(stable[0]), 32'd0);
        checkOutput("post_drop_changed", 32'(changed[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
